// File: rtl/thread_state_arb.sv
// thread_state_arb
// Owns the per-thread state array of one sha512unit and arbitrates every
// write to it. Three clients touch the array:
//   - CPU: lookahead read port (registered) plus a write port that is never
//     stalled.
//   - Loader: a round-robin scheduler reserves a NONE thread and offers it;
//     the loader's completion writes WR_RDY.
//   - Unloader: a round-robin scheduler reserves an RD_RDY thread and offers
//     it; the unloader's completion writes NONE.
//
// Handshake (loader shown, unloader identical):
//   ld_valid_o=1 means ld_num_o is reserved for the loader and stays frozen.
//   The loader raises ld_done_i and holds it until it sees ld_ack_o. A done
//   request is granted in the first cycle the write port is free; in the
//   following cycle ld_ack_o pulses for exactly one cycle and ld_valid_o
//   drops. ld_done_i while ld_valid_o=0 is ignored.
//
// Write port priority: CPU > unloader > loader, one write per cycle.
// Schedulers and the read port see the registered array, so a write made in
// cycle t is visible to them from cycle t+1 (ts_rd_o shows it in t+2).
module thread_state_arb #(
  parameter int N_CORES       = 4,
  parameter int N_THREADS     = 4 * N_CORES,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // CPU / thread_number side
  input  logic [N_THREADS_MSB:0]   ts_rd_num_i,
  output logic [1:0]               ts_rd_o,
  input  logic                     cpu_wr_en_i,
  input  logic [N_THREADS_MSB:0]   cpu_wr_num_i,
  input  logic [1:0]               cpu_wr_state_i,
  // loader side
  output logic                     ld_valid_o,
  output logic [N_THREADS_MSB:0]   ld_num_o,
  input  logic                     ld_done_i,
  output logic                     ld_ack_o,
  // unloader side
  output logic                     ul_valid_o,
  output logic [N_THREADS_MSB:0]   ul_num_o,
  input  logic                     ul_done_i,
  output logic                     ul_ack_o,
  // scheduler state for observation: 1 = OFFER, 0 = SCAN
  output logic                     dbg_ld_offer_o,
  output logic                     dbg_ul_offer_o
);

  localparam int TW = N_THREADS_MSB + 1;

  // Thread state codes (2'd3 is BUSY, only ever written by the CPU).
  localparam logic [1:0] ST_NONE   = 2'd0;
  localparam logic [1:0] ST_WR_RDY = 2'd1;
  localparam logic [1:0] ST_RD_RDY = 2'd2;

  localparam logic [TW-1:0] LAST_THR  = TW'(N_THREADS - 1);
  localparam logic [TW:0]   N_THR_EXT = (TW + 1)'(N_THREADS);

  typedef enum logic {
    SCH_SCAN  = 1'b0,
    SCH_OFFER = 1'b1
  } sched_e;

  // Round-robin step with explicit wrap so non power-of-two counts work.
  function automatic logic [TW-1:0] ptr_next(input logic [TW-1:0] p);
    return (p == LAST_THR) ? '0 : p + 1'b1;
  endfunction

  // True when a thread number addresses a real array entry.
  function automatic logic in_range(input logic [TW-1:0] n);
    return ({1'b0, n} < N_THR_EXT);
  endfunction

  // ---------------------------------------------------------------------
  // State array and read port
  // ---------------------------------------------------------------------
  logic [1:0]    state_q [N_THREADS];
  logic [1:0]    ts_rd_q;

  logic          wr_en;
  logic [TW-1:0] wr_idx;
  logic [1:0]    wr_data;

  // Registered lookahead read; no bypass from a same-cycle write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_rd_q <= ST_NONE;
    end else if (in_range(ts_rd_num_i)) begin
      ts_rd_q <= state_q[ts_rd_num_i];
    end else begin
      ts_rd_q <= ST_NONE;
    end
  end

  // Single write port into the thread state array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_THREADS; i++) begin
        state_q[i] <= ST_NONE;
      end
    end else if (wr_en) begin
      state_q[wr_idx] <= wr_data;
    end
  end

  assign ts_rd_o = ts_rd_q;

  // ---------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------
  logic          ld_valid_q;
  logic [TW-1:0] ld_num_q;
  logic          ld_ack_q;
  logic [TW-1:0] ld_ptr_q;
  sched_e        ld_st_q;

  logic          ul_valid_q;
  logic [TW-1:0] ul_num_q;
  logic          ul_ack_q;
  logic [TW-1:0] ul_ptr_q;
  sched_e        ul_st_q;

  logic          cpu_go;
  logic          ld_req;
  logic          ul_req;
  logic          ld_grant;
  logic          ul_grant;

  // Fixed priority CPU > unloader > loader. Requests only count while the
  // matching offer is live, so stray done pulses never reach the array.
  // An out-of-range CPU write is dropped and does not block the others.
  always_comb begin
    cpu_go   = cpu_wr_en_i & in_range(cpu_wr_num_i);
    ld_req   = ld_valid_q & ld_done_i;
    ul_req   = ul_valid_q & ul_done_i;
    ul_grant = ul_req & ~cpu_go;
    ld_grant = ld_req & ~cpu_go & ~ul_req;

    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = ST_NONE;
    if (cpu_go) begin
      wr_en   = 1'b1;
      wr_idx  = cpu_wr_num_i;
      wr_data = cpu_wr_state_i;
    end else if (ul_grant) begin
      wr_en   = 1'b1;
      wr_idx  = ul_num_q;
      wr_data = ST_NONE;
    end else if (ld_grant) begin
      wr_en   = 1'b1;
      wr_idx  = ld_num_q;
      wr_data = ST_WR_RDY;
    end
  end

  // ---------------------------------------------------------------------
  // Loader scheduler: look for a NONE thread, offer it, wait for the write
  // ---------------------------------------------------------------------
  // Scanning stops while an offer is outstanding; the pointer resumes one
  // past the thread just handed back so every thread gets its turn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_st_q    <= SCH_SCAN;
      ld_ptr_q   <= '0;
      ld_num_q   <= '0;
      ld_valid_q <= 1'b0;
      ld_ack_q   <= 1'b0;
    end else begin
      ld_ack_q <= 1'b0;
      case (ld_st_q)
        SCH_SCAN: begin
          if (state_q[ld_ptr_q] == ST_NONE) begin
            ld_valid_q <= 1'b1;
            ld_num_q   <= ld_ptr_q;
            ld_st_q    <= SCH_OFFER;
          end else begin
            ld_ptr_q <= ptr_next(ld_ptr_q);
          end
        end
        SCH_OFFER: begin
          if (ld_grant) begin
            ld_valid_q <= 1'b0;
            ld_ack_q   <= 1'b1;
            ld_ptr_q   <= ptr_next(ld_num_q);
            ld_st_q    <= SCH_SCAN;
          end
        end
        default: begin
          ld_st_q <= SCH_SCAN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Unloader scheduler: look for an RD_RDY thread, offer it, wait for the
  // write that returns it to NONE
  // ---------------------------------------------------------------------
  // Same round-robin discipline as the loader with an independent pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ul_st_q    <= SCH_SCAN;
      ul_ptr_q   <= '0;
      ul_num_q   <= '0;
      ul_valid_q <= 1'b0;
      ul_ack_q   <= 1'b0;
    end else begin
      ul_ack_q <= 1'b0;
      case (ul_st_q)
        SCH_SCAN: begin
          if (state_q[ul_ptr_q] == ST_RD_RDY) begin
            ul_valid_q <= 1'b1;
            ul_num_q   <= ul_ptr_q;
            ul_st_q    <= SCH_OFFER;
          end else begin
            ul_ptr_q <= ptr_next(ul_ptr_q);
          end
        end
        SCH_OFFER: begin
          if (ul_grant) begin
            ul_valid_q <= 1'b0;
            ul_ack_q   <= 1'b1;
            ul_ptr_q   <= ptr_next(ul_num_q);
            ul_st_q    <= SCH_SCAN;
          end
        end
        default: begin
          ul_st_q <= SCH_SCAN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign ld_valid_o     = ld_valid_q;
  assign ld_num_o       = ld_num_q;
  assign ld_ack_o       = ld_ack_q;
  assign ul_valid_o     = ul_valid_q;
  assign ul_num_o       = ul_num_q;
  assign ul_ack_o       = ul_ack_q;
  assign dbg_ld_offer_o = (ld_st_q == SCH_OFFER);
  assign dbg_ul_offer_o = (ul_st_q == SCH_OFFER);

endmodule

// File: tb/tb_thread_state_arb.sv
// Bench for thread_state_arb with 16 threads: a per-cycle vector table for
// the single-step behaviour plus hand-written sequences for wrap-around,
// async reset during an offer and a full read sweep.
module tb_thread_state_arb;

  localparam int NT = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic [3:0] ts_rd_num;
  logic [1:0] ts_rd;
  logic       cpu_wr_en;
  logic [3:0] cpu_wr_num;
  logic [1:0] cpu_wr_state;
  logic       ld_valid;
  logic [3:0] ld_num;
  logic       ld_done;
  logic       ld_ack;
  logic       ul_valid;
  logic [3:0] ul_num;
  logic       ul_done;
  logic       ul_ack;
  logic       dbg_ld_offer;
  logic       dbg_ul_offer;

  thread_state_arb #(.N_CORES(4), .N_THREADS(NT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ts_rd_num_i    (ts_rd_num),
    .ts_rd_o        (ts_rd),
    .cpu_wr_en_i    (cpu_wr_en),
    .cpu_wr_num_i   (cpu_wr_num),
    .cpu_wr_state_i (cpu_wr_state),
    .ld_valid_o     (ld_valid),
    .ld_num_o       (ld_num),
    .ld_done_i      (ld_done),
    .ld_ack_o       (ld_ack),
    .ul_valid_o     (ul_valid),
    .ul_num_o       (ul_num),
    .ul_done_i      (ul_done),
    .ul_ack_o       (ul_ack),
    .dbg_ld_offer_o (dbg_ld_offer),
    .dbg_ul_offer_o (dbg_ul_offer)
  );

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       cpu_en;
    logic [3:0] cpu_num;
    logic [1:0] cpu_st;
    logic       ld_dn;
    logic       ul_dn;
    logic [3:0] rd_num;
    logic [1:0] e_ts;
    logic       e_ldv;
    logic [3:0] e_ldn;
    logic       e_lda;
    logic       e_ulv;
    logic [3:0] e_uln;
    logic       e_ula;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c_en, input int c_num, input int c_st,
                              input logic l_dn, input logic u_dn, input int rd,
                              input int ts, input logic ldv, input int ldn,
                              input logic lda, input logic ulv, input int uln,
                              input logic ula);
    vec_t v;
    v.cpu_en  = c_en;
    v.cpu_num = 4'(c_num);
    v.cpu_st  = 2'(c_st);
    v.ld_dn   = l_dn;
    v.ul_dn   = u_dn;
    v.rd_num  = 4'(rd);
    v.e_ts    = 2'(ts);
    v.e_ldv   = ldv;
    v.e_ldn   = 4'(ldn);
    v.e_lda   = lda;
    v.e_ulv   = ulv;
    v.e_uln   = 4'(uln);
    v.e_ula   = ula;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cpu_wr_en    = 1'b0;
    cpu_wr_num   = '0;
    cpu_wr_state = '0;
    ld_done      = 1'b0;
    ul_done      = 1'b0;
  endtask

  // Returns on a negedge with reset released.
  task automatic apply_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits up to max_cyc edges for ld_valid; returns at posedge+1.
  task automatic wait_ld_valid(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      #1;
      if (ld_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ok;
    rst       = 1'b1;
    ts_rd_num = '0;
    drive_idle();

    // Reset values with reset held
    @(negedge clk);
    @(negedge clk);
    chk("rst_ts_rd", 8'(ts_rd), 8'd0);
    chk("rst_ld_valid", 8'(ld_valid), 8'd0);
    chk("rst_ld_num", 8'(ld_num), 8'd0);
    chk("rst_ld_ack", 8'(ld_ack), 8'd0);
    chk("rst_ul_valid", 8'(ul_valid), 8'd0);
    chk("rst_ul_num", 8'(ul_num), 8'd0);
    chk("rst_ul_ack", 8'(ul_ack), 8'd0);

    // Per-cycle table: inputs for a cycle, outputs expected after its edge.
    //                  cpu en,num,st  ld ul rd | ts ldv ldn lda ulv uln ula
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0)); // first offer
    vecs.push_back(mk(0, 0, 0, 1, 0, 3,   0, 0, 0, 1, 0, 0, 0)); // ld grant thr0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0)); // WR_RDY visible, offer 1
    vecs.push_back(mk(1, 9, 2, 0, 0, 9,   0, 1, 1, 0, 0, 0, 0)); // cpu thr9 <- RD_RDY
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 9, 2, 1, 1, 0, 0, 0, 0)); // ul_ptr 5..9
    vecs.push_back(mk(0, 0, 0, 0, 0, 9,   2, 1, 1, 0, 1, 9, 0)); // ul offers 9
    vecs.push_back(mk(0, 0, 0, 0, 1, 9,   2, 1, 1, 0, 0, 9, 1)); // ul grant thr9
    vecs.push_back(mk(0, 0, 0, 0, 0, 9,   0, 1, 1, 0, 0, 9, 0)); // thr9 NONE
    vecs.push_back(mk(1, 12, 2, 0, 0, 12, 0, 1, 1, 0, 0, 9, 0)); // cpu thr12 <- RD_RDY
    vecs.push_back(mk(0, 0, 0, 0, 0, 12,  2, 1, 1, 0, 1, 12, 0)); // ul offers 12
    vecs.push_back(mk(1, 5, 2, 1, 1, 5,   0, 1, 1, 0, 1, 12, 0)); // cpu wins
    vecs.push_back(mk(0, 0, 0, 1, 1, 5,   2, 1, 1, 0, 0, 12, 1)); // ul wins
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 12, 0)); // ld last
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 2, 0, 0, 12, 0)); // offer 2
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 5, 2, 1, 2, 0, 0, 12, 0)); // ul_ptr wraps to 5
    vecs.push_back(mk(0, 0, 0, 0, 0, 5,   2, 1, 2, 0, 1, 5, 0)); // ul offers 5
    vecs.push_back(mk(0, 0, 0, 0, 1, 5,   2, 1, 2, 0, 0, 5, 1)); // ul grant thr5
    vecs.push_back(mk(0, 0, 0, 0, 1, 5,   0, 1, 2, 0, 0, 5, 0)); // stray ul_done ignored

    // Reset released on this negedge; the first row is the first cycle.
    rst = 1'b0;
    foreach (vecs[i]) begin
      cpu_wr_en    = vecs[i].cpu_en;
      cpu_wr_num   = vecs[i].cpu_num;
      cpu_wr_state = vecs[i].cpu_st;
      ld_done      = vecs[i].ld_dn;
      ul_done      = vecs[i].ul_dn;
      ts_rd_num    = vecs[i].rd_num;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_ts_rd", i), 8'(ts_rd), 8'(vecs[i].e_ts));
      chk($sformatf("r%0d_ld_valid", i), 8'(ld_valid), 8'(vecs[i].e_ldv));
      chk($sformatf("r%0d_ld_num", i), 8'(ld_num), 8'(vecs[i].e_ldn));
      chk($sformatf("r%0d_ld_ack", i), 8'(ld_ack), 8'(vecs[i].e_lda));
      chk($sformatf("r%0d_ul_valid", i), 8'(ul_valid), 8'(vecs[i].e_ulv));
      chk($sformatf("r%0d_ul_num", i), 8'(ul_num), 8'(vecs[i].e_uln));
      chk($sformatf("r%0d_ul_ack", i), 8'(ul_ack), 8'(vecs[i].e_ula));
      @(negedge clk);
    end
    drive_idle();

    // Wrap: threads 1..14 WR_RDY by CPU, thread 0 by the loader, then 15.
    apply_reset();
    for (int i = 1; i < NT - 1; i++) begin
      cpu_wr_en    = 1'b1;
      cpu_wr_num   = 4'(i);
      cpu_wr_state = 2'd1;
      @(posedge clk);
      @(negedge clk);
    end
    cpu_wr_en = 1'b0;
    ld_done   = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap_ack0", 8'(ld_ack), 8'd1);
    @(negedge clk);
    ld_done = 1'b0;
    wait_ld_valid(40, ok);
    chk("wrap_offer15_seen", 8'(ok), 8'd1);
    chk("wrap_offer15_num", 8'(ld_num), 8'd15);
    @(negedge clk);
    ld_done = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap_ack15", 8'(ld_ack), 8'd1);
    chk("wrap_valid_drop", 8'(ld_valid), 8'd0);
    @(negedge clk);
    ld_done      = 1'b0;
    cpu_wr_en    = 1'b1;
    cpu_wr_num   = 4'd0;
    cpu_wr_state = 2'd0;
    ts_rd_num    = 4'd15;
    @(posedge clk);
    @(negedge clk);
    cpu_wr_en = 1'b0;
    wait_ld_valid(40, ok);
    chk("wrap_offer0_seen", 8'(ok), 8'd1);
    chk("wrap_offer0_num", 8'(ld_num), 8'd0);
    chk("wrap_thr15_wr_rdy", 8'(ts_rd), 8'd1);
    chk("wrap_ul_idle", 8'(ul_valid), 8'd0);

    // Async reset while offering thread 0 with ld_done held.
    @(negedge clk);
    ld_done = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ld_valid", 8'(ld_valid), 8'd0);
    chk("arst_ld_num", 8'(ld_num), 8'd0);
    chk("arst_ld_ack", 8'(ld_ack), 8'd0);
    chk("arst_ts_rd", 8'(ts_rd), 8'd0);
    chk("arst_dbg_ld", 8'(dbg_ld_offer), 8'd0);
    @(posedge clk);
    #1;
    chk("arst_no_ack", 8'(ld_ack), 8'd0);
    @(negedge clk);
    ld_done = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ld_valid", 8'(ld_valid), 8'd1);
    chk("rel_ld_num", 8'(ld_num), 8'd0);
    chk("rel_ul_valid", 8'(ul_valid), 8'd0);
    chk("rel_dbg_ld", 8'(dbg_ld_offer), 8'd1);
    chk("rel_dbg_ul", 8'(dbg_ul_offer), 8'd0);

    // Every thread reads NONE after reset, thread 0 included.
    for (int n = 0; n < NT; n++) begin
      @(negedge clk);
      ts_rd_num = 4'(n);
      exp_q.push_back(2'd0);
      @(posedge clk);
      #1;
      chk($sformatf("sweep_thr%0d", n), 8'(ts_rd), 8'(exp_q.pop_front()));
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
